// File: rtl/finv_arb_pkg.sv
// Shared types, binary32 field positions and the operand flush helper used by
// the finv sharing arbiter and its reciprocal unit.
package finv_arb_pkg;

    localparam int NREQ_MAX = 8;
    localparam int TAG_W    = $clog2(NREQ_MAX);

    typedef logic [TAG_W-1:0] tag_t;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MANT_W  = 23;

    // Subnormals become a signed zero; everything else, NaN/Inf included, is untouched.
    function automatic logic [31:0] flush_subnormal(input logic [31:0] x);
        logic [31:0] r;
        r = x;
        if (x[EXP_MSB:EXP_LSB] == 8'd0) begin
            r[MANT_W-1:0] = {MANT_W{1'b0}};
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/finv.sv
// Pipelined binary32 reciprocal: y is valid NSTAGE cycles after x is presented.
// Mantissa is truncated; results that would be subnormal are flushed to zero.
module finv
    import finv_arb_pkg::*;
#(
    parameter int NSTAGE = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [7:0]  exp_s;
    logic [47:0] quot_s;
    logic [31:0] recip_s;
    logic        unused_quot_s;
    logic [31:0] pipe_r [NSTAGE];

    assign exp_s         = x[EXP_MSB:EXP_LSB];
    assign unused_quot_s = ^quot_s[47:23];

    // 2^47 / 1.f lands in (2^23, 2^24), so its low 23 bits are the result fraction.
    always_comb begin
        quot_s = 48'h8000_0000_0000 / {24'd0, 1'b1, x[MANT_W-1:0]};
        if (exp_s == 8'd0) begin
            recip_s = {x[31], 8'hFF, 23'd0};
        end else if (exp_s == 8'hFF) begin
            if (x[MANT_W-1:0] != 23'd0) begin
                recip_s = 32'h7FC0_0000;
            end else begin
                recip_s = {x[31], 31'd0};
            end
        end else if (x[MANT_W-1:0] == 23'd0) begin
            if (exp_s <= 8'd253) begin
                recip_s = {x[31], 8'd254 - exp_s, 23'd0};
            end else begin
                recip_s = {x[31], 31'd0};
            end
        end else if (exp_s <= 8'd252) begin
            recip_s = {x[31], 8'd253 - exp_s, quot_s[22:0]};
        end else begin
            recip_s = {x[31], 31'd0};
        end
    end

    // Latency pipeline behind the reciprocal.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NSTAGE; k++) begin
                pipe_r[k] <= 32'd0;
            end
        end else begin
            pipe_r[0] <= recip_s;
            for (int k = 1; k < NSTAGE; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
        end
    end

    assign y = pipe_r[NSTAGE-1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first eligible requester at or after ptr,
// wrapping. The pointer register lives in the parent.
module rr_arbiter
    import finv_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] elig,
    input  tag_t         ptr,
    output logic [N-1:0] grant,
    output tag_t         grant_idx
);

    int best_d;
    int d;

    // Pick the eligible requester with the smallest rotated distance from ptr.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        best_d    = N;
        d         = 0;
        for (int i = 0; i < N; i++) begin
            d = i - int'(ptr);
            if (d < 0) begin
                d = d + N;
            end else begin
                d = d;
            end
            if (elig[i] && (d < best_d)) begin
                best_d    = d;
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = tag_t'(i);
            end else begin
                best_d = best_d;
            end
        end
    end

endmodule

// File: rtl/finv_share_arb.sv
// Shares one pipelined finv unit among NREQ requesters with round-robin issue,
// a tag shadow pipeline for result routing and per-requester credit limits.
module finv_share_arb
    import finv_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int NSTAGE = 2,
    parameter int MAXOUT = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*32-1:0]          req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0]             resp_valid,
    output logic [31:0]                 resp_data,
    output logic [$clog2(NSTAGE+2)-1:0] inflight,
    output logic [31:0]                 issue_cnt
);

    localparam int            CW       = $clog2(MAXOUT + 1);
    localparam int            IW       = $clog2(NSTAGE + 2);
    localparam logic [CW-1:0] MAXOUT_C = CW'(MAXOUT);
    localparam tag_t          LAST_TAG = tag_t'(NREQ - 1);

    logic [CW-1:0]   cred_r [NREQ];
    tag_t            ptr_r;
    logic [31:0]     x1_r;
    logic [NSTAGE:0] shadow_v_r;
    tag_t            shadow_tag_r [NSTAGE+1];
    logic [IW-1:0]   inflight_r;
    logic [31:0]     issue_cnt_r;

    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] grant_s;
    logic [NREQ-1:0] resp_hit_s;
    tag_t            grant_idx_s;
    logic            issue_s;
    logic [31:0]     operand_s;
    logic [31:0]     y_s;

    // A requester competes only while it holds an operand and has credit left.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig_s[i] = req_valid[i] && (cred_r[i] < MAXOUT_C);
        end
    end

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .elig      (elig_s),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign issue_s   = |grant_s;
    assign req_ready = grant_s;

    // Select the granted operand.
    always_comb begin
        operand_s = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                operand_s = req_data[32*i +: 32];
            end else begin
                operand_s = operand_s;
            end
        end
    end

    // Decode the tag leaving the shadow pipeline alongside finv y.
    always_comb begin
        resp_hit_s = '0;
        for (int t = 0; t < NREQ; t++) begin
            resp_hit_s[t] = shadow_v_r[NSTAGE] && (shadow_tag_r[NSTAGE] == tag_t'(t));
        end
    end

    assign resp_valid = resp_hit_s;
    assign resp_data  = y_s;
    assign inflight   = inflight_r;
    assign issue_cnt  = issue_cnt_r;

    // Issue register, shadow pipeline, pointer and global counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r       <= '0;
            x1_r        <= 32'd0;
            shadow_v_r  <= '0;
            inflight_r  <= '0;
            issue_cnt_r <= 32'd0;
            for (int k = 0; k <= NSTAGE; k++) begin
                shadow_tag_r[k] <= '0;
            end
        end else begin
            shadow_v_r[0]   <= issue_s;
            shadow_tag_r[0] <= grant_idx_s;
            for (int k = 1; k <= NSTAGE; k++) begin
                shadow_v_r[k]   <= shadow_v_r[k-1];
                shadow_tag_r[k] <= shadow_tag_r[k-1];
            end
            if (issue_s) begin
                x1_r        <= flush_subnormal(operand_s);
                issue_cnt_r <= issue_cnt_r + 32'd1;
                if (grant_idx_s == LAST_TAG) begin
                    ptr_r <= '0;
                end else begin
                    ptr_r <= grant_idx_s + tag_t'(1);
                end
            end
            case ({issue_s, shadow_v_r[NSTAGE]})
                2'b10:   inflight_r <= inflight_r + IW'(1);
                2'b01:   inflight_r <= inflight_r - IW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Credits: issue adds one, a response returns one, both together cancel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) begin
                cred_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({grant_s[i], resp_hit_s[i]})
                    2'b10:   cred_r[i] <= cred_r[i] + CW'(1);
                    2'b01:   cred_r[i] <= cred_r[i] - CW'(1);
                    default: cred_r[i] <= cred_r[i];
                endcase
            end
        end
    end

    finv #(
        .NSTAGE (NSTAGE)
    ) u_finv (
        .clk  (clk),
        .rstn (rstn),
        .x    (x1_r),
        .y    (y_s)
    );

endmodule

// File: tb/tb_finv_share_arb.sv
// Scoreboard bench for finv_share_arb: directed scenarios plus random traffic,
// checked against a real-arithmetic reciprocal and an in-order issue queue.
module tb_finv_share_arb;

    localparam int NREQ   = 2;
    localparam int NSTAGE = 2;
    localparam int MAXOUT = 2;
    localparam int IW     = $clog2(NSTAGE + 2);

    typedef struct {
        logic [31:0] op;
        int          req;
        longint      edge_no;
    } exp_t;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*32-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     resp_valid;
    logic [31:0]         resp_data;
    logic [IW-1:0]       inflight;
    logic [31:0]         issue_cnt;

    int          checks   = 0;
    int          failures = 0;
    longint      edge_cnt = 0;
    int          ptr_m;
    int          outst [NREQ];
    logic [31:0] icnt_m;
    logic [NREQ-1:0] last_ready;
    exp_t        sb [$];

    finv_share_arb #(
        .NREQ   (NREQ),
        .NSTAGE (NSTAGE),
        .MAXOUT (MAXOUT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .inflight   (inflight),
        .issue_cnt  (issue_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // 1/x through double-precision real arithmetic, truncated back to binary32.
    function automatic logic [31:0] ref_finv(input logic [31:0] a);
        logic        s;
        int          e;
        logic [63:0] db;
        real         r;
        s = a[31];
        e = int'(a[30:23]);
        if (e == 0) return {s, 8'hFF, 23'd0};
        if (e == 255) return (a[22:0] != 23'd0) ? 32'h7FC0_0000 : {s, 31'd0};
        db = {s, 11'(e - 127 + 1023), a[22:0], 29'd0};
        r  = 1.0 / $bitstoreal(db);
        db = $realtobits(r);
        e  = int'(db[62:52]) - 1023 + 127;
        if (e < 1) return {s, 31'd0};
        return {s, 8'(e), db[51:29]};
    endfunction

    function automatic bit close(input logic [31:0] a, input logic [31:0] b);
        int d;
        if (a === b) return 1'b1;
        if (a[31] != b[31]) return 1'b0;
        d = int'(a[30:0]) - int'(b[30:0]);
        return (d <= 5) && (d >= -5);
    endfunction

    function automatic logic [31:0] rand_op();
        int          k;
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        k = $urandom_range(0, 19);
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        if (k == 0) e = 8'd0;
        else if (k == 1) begin e = 8'd0; m = 23'd0; end
        else if (k == 2) begin e = 8'hFF; m = 23'd0; end
        else e = 8'($urandom_range(1, 250));
        return {s, e, m};
    endfunction

    task automatic drive(input logic [NREQ-1:0] v, input logic [31:0] d0, input logic [31:0] d1);
        req_valid = v;
        req_data  = {d1, d0};
    endtask

    // One cycle: check grant and counters at negedge, record any handshake, return at posedge+1.
    task automatic tick();
        int              g;
        int              tot;
        logic [NREQ-1:0] exp_ready;
        exp_t            e;
        @(negedge clk);
        g   = -1;
        tot = 0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr_m + k) % NREQ;
            if (g < 0 && req_valid[i] && outst[i] < MAXOUT) g = i;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            tot += outst[i];
            chk("cred", 64'(dut.cred_r[i]), 64'(outst[i]));
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("inflight", 64'(inflight), 64'(tot));
        chk("issue_cnt", 64'(issue_cnt), 64'(icnt_m));
        last_ready = req_ready;
        if (g >= 0) begin
            e.op      = req_data[32*g +: 32];
            e.req     = g;
            e.edge_no = edge_cnt;
            sb.push_back(e);
            outst[g]++;
            ptr_m  = (g + 1) % NREQ;
            icnt_m = icnt_m + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < NREQ; i++) outst[i] = 0;
        ptr_m      = 0;
        icnt_m     = 32'd0;
        last_ready = '0;
    endtask

    // Monitor: every presented response must be the oldest outstanding issue.
    initial begin
        exp_t        e;
        logic [31:0] want;
        forever begin
            @(negedge clk);
            #1;
            if (rstn === 1'b1 && resp_valid != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_unexpected actual=%b required=none", resp_valid);
                end else begin
                    e    = sb.pop_front();
                    want = ref_finv(e.op);
                    chk("resp_route", 64'(resp_valid), 64'(1) << e.req);
                    chk("resp_latency", 64'(edge_cnt), 64'(e.edge_no + 1 + NSTAGE));
                    checks++;
                    if (!close(resp_data, want)) begin
                        failures++;
                        $display("FAIL resp_data op=%h actual=%h required=%h", e.op, resp_data, want);
                    end
                    outst[e.req]--;
                end
            end
        end
    end

    initial begin
        logic [31:0] d1;
        rstn = 1'b0;
        drive('0, 32'd0, 32'd0);
        model_reset();
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_issue_cnt", 64'(issue_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        // Single request: 2.0 -> 0.5
        drive(2'b01, 32'h4000_0000, 32'd0);
        tick();
        drive('0, 32'd0, 32'd0);
        repeat (5) tick();

        // Contention: alternate grants, results routed back
        drive(2'b11, 32'h4080_0000, 32'h3E80_0000);
        repeat (6) tick();
        drive('0, 32'd0, 32'd0);
        repeat (5) tick();

        // Requester 1 alone until its credits run out
        d1 = 32'h3F80_0000;
        for (int c = 0; c < 10; c++) begin
            drive(2'b10, 32'd0, d1);
            tick();
            if (last_ready[1]) d1 = d1 + 32'h0010_0000;
        end
        drive('0, 32'd0, 32'd0);
        repeat (5) tick();

        // Subnormal operand is flushed before reaching finv
        drive(2'b01, 32'h8000_0001, 32'd0);
        tick();
        chk("flush_x1", 64'(dut.x1_r), 64'h8000_0000);
        drive('0, 32'd0, 32'd0);
        repeat (5) tick();

        // Reset with two operations in flight
        drive(2'b01, 32'h4040_0000, 32'd0);
        repeat (2) tick();
        drive('0, 32'd0, 32'd0);
        tick();
        chk("inflight_pre_reset", 64'(inflight), 64'd2);
        rstn = 1'b0;
        #1;
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_inflight", 64'(inflight), 64'd0);
        chk("midrst_issue_cnt", 64'(issue_cnt), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) tick();
        drive(2'b11, 32'h3F80_0000, 32'h40A0_0000);
        repeat (4) tick();
        drive('0, 32'd0, 32'd0);
        repeat (5) tick();

        // issue_cnt wraps from all-ones to zero
        force dut.issue_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.issue_cnt_r;
        icnt_m = 32'hFFFF_FFFF;
        drive(2'b01, 32'h4100_0000, 32'd0);
        tick();
        drive('0, 32'd0, 32'd0);
        tick();
        chk("issue_cnt_wrap", 64'(issue_cnt), 64'd0);
        repeat (4) tick();

        // Random traffic; a stalled requester holds its operand
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !last_ready[i])) begin
                    req_valid[i]         = ($urandom_range(0, 99) < 65);
                    req_data[32*i +: 32] = rand_op();
                end
            end
            tick();
        end
        drive('0, 32'd0, 32'd0);
        repeat (8) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
